expansion_shiftreg_target: RTL and testbench
============================================

EXPANSION_SHIFTREG_TARGET -- requirements
Module: expansion_shiftreg_target

Interface
REQ-001 SHALL have parameter WIDTH, default 8: frame length in bits, range 1..64.
REQ-002 SHALL have parameter TIMEOUT, default 5000000: clk cycles without a good frame before watchdog trips.
REQ-003 SHALL have port clk, input, 1 bit: single system clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port SHIFT_CLK, input, 1 bit: asynchronous serial clock from the remote master.
REQ-006 SHALL have port SHIFT_LOAD, input, 1 bit: asynchronous frame latch strobe from the master, idles high.
REQ-007 SHALL have port SHIFT_IN, input, 1 bit: asynchronous serial data from the master, MSB first.
REQ-008 SHALL have port SHIFT_OUT, output, 1 bit: serial data to the master, LSB first.
REQ-009 SHALL have port data_out, output, WIDTH bits: last good word received from the master.
REQ-010 SHALL have port data_in, input, WIDTH bits: word returned to the master in the next frame.
REQ-011 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-012 SHALL have port frame_error, output, 1 bit: one-cycle pulse on a frame with bit count not equal to WIDTH.
REQ-013 SHALL have port timeout, output, 1 bit: watchdog tripped, level signal.

Function
REQ-014 SHALL pass SHIFT_CLK, SHIFT_LOAD and SHIFT_IN each through a 2-FF synchronizer plus a previous-value register for edge detection, giving 3 clk of latency to each edge event.
REQ-015 SHALL run a two-state FSM: SHIFTING (LOAD high) and LATCH (LOAD low).
REQ-016 SHALL, in SHIFTING on a SHIFT_CLK rising edge, shift synced SHIFT_IN into the LSB of rx_shift (shifting left) and increment bit_cnt, saturating at WIDTH+1.
REQ-017 SHALL, in SHIFTING on a SHIFT_CLK falling edge, shift tx_shift right and drive its new bit 0 on SHIFT_OUT.
REQ-018 SHALL, on a SHIFT_LOAD falling edge, enter LATCH: if bit_cnt==WIDTH, load data_out from rx_shift and pulse frame_valid; otherwise pulse frame_error and leave data_out unchanged.
REQ-019 SHALL, on a SHIFT_LOAD rising edge, enter SHIFTING, load tx_shift from data_in, set SHIFT_OUT=data_in[0], and clear bit_cnt and rx_shift.
REQ-020 SHALL ignore SHIFT_CLK edges while in LATCH.
REQ-021 SHALL give the LOAD edge priority over a SHIFT_CLK edge detected in the same cycle, discarding the clock edge.
REQ-022 SHALL require the master to hold each SHIFT_CLK/SHIFT_LOAD level for at least 4 clk; faster input is unsupported, with no detection required.
REQ-023 SHALL assert frame_valid and frame_error only as single-cycle pulses and never in the same cycle.

Reset
REQ-024 SHALL, on reset, asynchronously set: data_out=0, SHIFT_OUT=0, frame_valid=0, frame_error=0, timeout=0, bit_cnt=0, rx_shift=0, tx_shift=0, state=SHIFTING.
REQ-025 SHALL reset the LOAD synchronizer stages to 1 and the CLK stages to 0, so no false edge appears after reset release.
REQ-026 SHALL abandon any partial frame when reset is asserted mid-frame; the first LOAD falling edge after reset reports frame_error unless exactly WIDTH clocks were seen.

Configuration
REQ-027 SHALL, with EXPANSION_SHIFTREG_TARGET_WATCHDOG_EN defined, implement a cycle counter as follows:
- clears on frame_valid;
- on reaching TIMEOUT, sets timeout=1 and data_out=0, and holds both until the next frame_valid.
REQ-028 SHALL, without EXPANSION_SHIFTREG_TARGET_WATCHDOG_EN, omit the counter and tie timeout to 0, keeping the port list identical.

Structure
REQ-029 SHALL place shared constants in package expansion_shiftreg_pkg:
- default WIDTH;
- default TIMEOUT;
- synchronizer depth (2);
- FSM state encoding.
REQ-030 SHALL implement synchronization plus edge detection in one sub-module, expansion_sync_edge (outputs: level, rise, fall), instantiated three times.

Verification
REQ-031 SHALL cover a good frame: WIDTH=8, data_in=0x5A, master sends 0xC3 MSB first at 10 clk per half-period, then LOAD pulse. Required: data_out=0xC3, one frame_valid pulse, master-sampled bits LSB first reassemble 0x5A.
REQ-032 SHALL cover a short frame: 7 clocks then LOAD low. Required: frame_error pulse, data_out holds its prior 0xC3, and the next 8-bit frame 0x01 gives data_out=0x01.
REQ-033 SHALL cover a long frame: 9 clocks then LOAD low. Required: frame_error pulse, bit_cnt saturated at 9, data_out unchanged.
REQ-034 SHALL cover a collision: SHIFT_CLK rise and SHIFT_LOAD fall arriving in the same synchronized cycle after 8 bits. Required: clock edge dropped, frame_valid pulse with the 8-bit word.
REQ-035 SHALL cover reset mid-frame: reset after 4 bits. Required: all outputs 0 immediately (asynchronous), and no frame_valid until a full new frame completes.
REQ-036 SHALL cover the watchdog with the macro defined and TIMEOUT=1000: no frames for 1000 clk. Required: timeout=1 and data_out=0; the next good frame 0xA5 clears timeout and sets data_out=0xA5. Without the macro, timeout stays 0.

Source files
------------

// File: rtl/expansion_shiftreg_pkg.sv
// Shared constants and FSM encoding for the expansion shift-register target.
package expansion_shiftreg_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 5000000;
  localparam int unsigned SYNC_DEPTH      = 2;

  typedef enum logic {
    SHIFTING = 1'b0,
    LATCH    = 1'b1
  } state_e;

endpackage

// File: rtl/expansion_shiftreg_target_sync.sv
// expansion_sync_edge: 2-FF synchronizer plus previous-value register giving
// registered level, rise and fall for one asynchronous input.
module expansion_sync_edge
  import expansion_shiftreg_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  synced;

  always_comb begin
    sync_d  = {sync_q[SYNC_DEPTH-2:0], async_in};
    synced  = sync_q[SYNC_DEPTH-1];
    level_d = synced;
    rise_d  = synced & ~level_q;
    fall_d  = ~synced & level_q;
  end

  // Reset to the idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_DEPTH{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/expansion_shiftreg_target.sv
// Serial shift-register target: receives MSB-first frames from a remote master and
// returns data_in LSB-first. Watchdog enabled by EXPANSION_SHIFTREG_TARGET_WATCHDOG_EN.
module expansion_shiftreg_target
  import expansion_shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SHIFT_CLK,
  input  logic             SHIFT_LOAD,
  input  logic             SHIFT_IN,
  output logic             SHIFT_OUT,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             timeout
);

`ifdef EXPANSION_SHIFTREG_TARGET_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  logic clk_level, clk_rise, clk_fall;
  logic load_level, load_rise, load_fall;
  logic in_level, in_rise, in_fall;

  expansion_sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .reset(reset), .async_in(SHIFT_CLK),
    .level(clk_level), .rise(clk_rise), .fall(clk_fall)
  );

  expansion_sync_edge #(.RESET_VAL(1'b1)) u_sync_load (
    .clk(clk), .reset(reset), .async_in(SHIFT_LOAD),
    .level(load_level), .rise(load_rise), .fall(load_fall)
  );

  expansion_sync_edge #(.RESET_VAL(1'b0)) u_sync_in (
    .clk(clk), .reset(reset), .async_in(SHIFT_IN),
    .level(in_level), .rise(in_rise), .fall(in_fall)
  );

  logic unused_sync_c;
  assign unused_sync_c = &{1'b0, clk_level, load_level, in_rise, in_fall};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             shift_out_q, shift_out_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             timeout_q, timeout_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;

  // Next-state and datapath: LOAD edges take priority over any SHIFT_CLK edge.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    data_out_d    = data_out_q;
    shift_out_d   = shift_out_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    timeout_d     = timeout_q;
    wd_cnt_d      = wd_cnt_q;
    tx_next       = tx_shift_q >> 1;

    if (load_fall) begin
      state_d = LATCH;
      if (bit_cnt_q == CNT_W'(WIDTH)) begin
        data_out_d    = rx_shift_q;
        frame_valid_d = 1'b1;
      end else begin
        frame_error_d = 1'b1;
      end
    end else if (load_rise) begin
      state_d     = SHIFTING;
      tx_shift_d  = data_in;
      shift_out_d = data_in[0];
      bit_cnt_d   = '0;
      rx_shift_d  = '0;
    end else if (state_q == SHIFTING) begin
      if (clk_rise) begin
        rx_shift_d = (rx_shift_q << 1) | WIDTH'(in_level);
        if (bit_cnt_q != CNT_W'(WIDTH + 1)) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      if (clk_fall) begin
        tx_shift_d  = tx_next;
        shift_out_d = tx_next[0];
      end
    end

    // Watchdog: counts clk since the last good frame, blanks data_out once tripped.
    if (WD_EN) begin
      if (frame_valid_d) begin
        wd_cnt_d  = '0;
        timeout_d = 1'b0;
      end else if (timeout_q || (wd_cnt_q == WD_W'(TIMEOUT - 1))) begin
        timeout_d  = 1'b1;
        data_out_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end else begin
      wd_cnt_d  = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SHIFTING;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      data_out_q    <= '0;
      shift_out_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      timeout_q     <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      data_out_q    <= data_out_d;
      shift_out_q   <= shift_out_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      timeout_q     <= timeout_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign SHIFT_OUT   = shift_out_q;
  assign data_out    = data_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_expansion_shiftreg_target.sv
// Bench for expansion_shiftreg_target: a bit-level master plus a frame-level model
// of data_out/timeout/pulses; honours EXPANSION_SHIFTREG_TARGET_WATCHDOG_EN.
module tb_expansion_shiftreg_target;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 1000;
`ifdef EXPANSION_SHIFTREG_TARGET_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             SHIFT_CLK = 1'b0;
  logic             SHIFT_LOAD = 1'b1;
  logic             SHIFT_IN = 1'b0;
  logic             SHIFT_OUT;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_in = '0;
  logic             frame_valid;
  logic             frame_error;
  logic             timeout;

  expansion_shiftreg_target #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .SHIFT_CLK(SHIFT_CLK), .SHIFT_LOAD(SHIFT_LOAD), .SHIFT_IN(SHIFT_IN),
    .SHIFT_OUT(SHIFT_OUT), .data_out(data_out), .data_in(data_in),
    .frame_valid(frame_valid), .frame_error(frame_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fv_total = 0;
  int fe_total = 0;
  int anchor = 0;
  bit window = 1'b0;
  bit in_reset = 1'b1;
  bit prev_fv = 1'b0;
  bit prev_fe = 1'b0;
  logic [WIDTH-1:0] last_good = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the frame-level model.
  task automatic cycle_check();
    int  since;
    bit  exp_to;
    cyc++;
    if (frame_valid || frame_error) begin
      check("pulse_exclusive", 64'(frame_valid & frame_error), 64'd0);
      check("pulse_single", 64'((frame_valid & prev_fv) | (frame_error & prev_fe)), 64'd0);
    end
    fv_total += int'(frame_valid);
    fe_total += int'(frame_error);
    prev_fv = frame_valid;
    prev_fe = frame_error;
    if (!window && !in_reset) begin
      since = cyc - anchor;
      if (!WD || since < int'(TIMEOUT) - 3 || since > int'(TIMEOUT) + 3) begin
        exp_to = WD && (since >= int'(TIMEOUT));
        check("data_out_model", 64'(data_out), exp_to ? 64'd0 : 64'(last_good));
        check("timeout_model", 64'(timeout), 64'(exp_to));
      end
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #1;
    end
  endtask

  // One master frame: optional LOAD rise, n SHIFT_CLK pulses, then LOAD fall.
  task automatic run_frame(input int n, input logic [WIDTH-1:0] word, input logic [WIDTH-1:0] din,
                           input int half, input bit collide, input string tag,
                           output logic [63:0] got);
    bit               raise;
    bit               good;
    logic [WIDTH-1:0] txw;
    int               fv0, fe0, fall_cyc, exp_cnt;
    raise = (SHIFT_LOAD == 1'b0);
    txw = raise ? din : '0;
    data_in = din;
    SHIFT_LOAD = 1'b1;
    wait_clk(half);
    got = '0;
    for (int i = 0; i < n; i++) begin
      SHIFT_IN = (n == int'(WIDTH)) ? word[WIDTH-1-i] : 1'($urandom);
      wait_clk(half);
      got[i] = SHIFT_OUT;
      SHIFT_CLK = 1'b1;
      wait_clk(half);
      SHIFT_CLK = 1'b0;
    end
    SHIFT_IN = 1'($urandom);
    wait_clk(half);
    exp_cnt = (n > int'(WIDTH) + 1) ? int'(WIDTH) + 1 : n;
    check({tag, "_bit_cnt"}, 64'(dut.bit_cnt_q), 64'(exp_cnt));
    fv0 = fv_total;
    fe0 = fe_total;
    window = 1'b1;
    if (collide) SHIFT_CLK = 1'b1;
    SHIFT_LOAD = 1'b0;
    fall_cyc = cyc;
    wait_clk(10);
    SHIFT_CLK = 1'b0;
    good = (n == int'(WIDTH));
    check({tag, "_valid_pulses"}, 64'(fv_total - fv0), 64'(good));
    check({tag, "_error_pulses"}, 64'(fe_total - fe0), 64'(!good));
    check({tag, "_tx_bits"}, got, 64'(txw) & ((64'd1 << n) - 64'd1));
    if (good) begin
      last_good = word;
      anchor = fall_cyc + 4;
    end
    window = 1'b0;
    wait_clk(half);
  endtask

  initial begin
    logic [63:0] got;
    int          n;
    logic [WIDTH-1:0] w;

    #2;
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_shift_out", 64'(SHIFT_OUT), 64'd0);
    check("reset_pulses", 64'({frame_valid, frame_error, timeout}), 64'd0);
    wait_clk(3);
    reset = 1'b0;
    anchor = cyc;
    in_reset = 1'b0;
    wait_clk(5);

    // Good frame: prime data_in with a LOAD pulse, then 0xC3 in / 0x5A out.
    run_frame(0, 8'h00, 8'h5A, 10, 1'b0, "prime", got);
    run_frame(8, 8'hC3, 8'h5A, 10, 1'b0, "good", got);
    check("good_data_out", 64'(data_out), 64'hC3);
    check("good_tx_word", got, 64'h5A);

    run_frame(7, 8'h00, 8'h11, 10, 1'b0, "short", got);
    check("short_data_out_held", 64'(data_out), 64'hC3);
    run_frame(8, 8'h01, 8'h22, 10, 1'b0, "after_short", got);
    check("after_short_data_out", 64'(data_out), 64'h01);
    check("after_short_tx_word", got, 64'h22);

    run_frame(9, 8'h00, 8'h33, 10, 1'b0, "long", got);
    check("long_data_out_held", 64'(data_out), 64'h01);

    run_frame(8, 8'h96, 8'h44, 10, 1'b1, "collide", got);
    check("collide_data_out", 64'(data_out), 64'h96);

    // Reset four bits into a frame.
    data_in = 8'h77;
    SHIFT_LOAD = 1'b1;
    wait_clk(10);
    for (int i = 0; i < 4; i++) begin
      SHIFT_IN = 1'($urandom);
      wait_clk(10);
      SHIFT_CLK = 1'b1;
      wait_clk(10);
      SHIFT_CLK = 1'b0;
    end
    wait_clk(3);
    reset = 1'b1;
    in_reset = 1'b1;
    #1;
    check("midreset_data_out", 64'(data_out), 64'd0);
    check("midreset_shift_out", 64'(SHIFT_OUT), 64'd0);
    check("midreset_pulses", 64'({frame_valid, frame_error, timeout}), 64'd0);
    wait_clk(3);
    reset = 1'b0;
    last_good = '0;
    anchor = cyc;
    in_reset = 1'b0;
    wait_clk(5);
    run_frame(0, 8'h00, 8'h55, 10, 1'b0, "post_reset_partial", got);
    run_frame(8, 8'h3C, 8'h66, 10, 1'b0, "post_reset_full", got);
    check("post_reset_data_out", 64'(data_out), 64'h3C);

`ifdef EXPANSION_SHIFTREG_TARGET_WATCHDOG_EN
    wait_clk(int'(TIMEOUT) + 100);
    check("wd_timeout_set", 64'(timeout), 64'd1);
    check("wd_data_out_cleared", 64'(data_out), 64'd0);
    run_frame(8, 8'hA5, 8'h0F, 10, 1'b0, "wd_recover", got);
    check("wd_timeout_cleared", 64'(timeout), 64'd0);
    check("wd_recover_data_out", 64'(data_out), 64'hA5);
`else
    wait_clk(int'(TIMEOUT) + 100);
    check("no_wd_timeout_low", 64'(timeout), 64'd0);
    check("no_wd_data_out_kept", 64'(data_out), 64'h3C);
`endif

    // Randomized frames: mostly full length, some short/long/saturating, a few collisions.
    for (int f = 0; f < 40; f++) begin
      n = ($urandom_range(0, 2) == 0) ? int'(WIDTH) - 2 + int'($urandom_range(0, 5)) : int'(WIDTH);
      w = WIDTH'($urandom);
      run_frame(n, w, WIDTH'($urandom), int'($urandom_range(6, 12)),
                (n == int'(WIDTH)) && ($urandom_range(0, 5) == 0), "rand", got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
